// File: rtl/ace_tape_player.sv
`default_nettype none
// ============================================================================
//  Module      : ace_tape_player
//  Description : Tape playback sequencer for the Jupiter ACE core. Reads a
//                downloaded .TAP image byte by byte over a req/ack port. It
//                parses the little-endian 16-bit block lengths and drives the
//                EAR line with the ACE ROM waveform: leader, sync, data bits
//                (MSB first) and an inter-block gap.
//  Ports       : clk_sys            system clock
//                reset              synchronous, active-low
//                ce                 tick enable, all waveform timing counts ce
//                pause              (ACE_TAPE_PAUSE_EN only) freeze playback
//                start / stop       begin at address 0 / abort to IDLE
//                file_size          image length in bytes, sampled on start
//                rd_req/rd_addr     byte read request, held until rd_ack
//                rd_data/rd_ack     read data with one-cycle acknowledge
//                ear                tape signal to the core
//                busy               high in any state except IDLE
//                block_cnt          completed blocks, wraps at 255
//  Options     : `define ACE_TAPE_PAUSE_EN adds the pause input
//  Revision    : 1.0 - initial release
// ============================================================================
module ace_tape_player #(
    parameter int AW          = 25,
    parameter int LEADER_HALF = 2011,
    parameter int HDR_PULSES  = 8192,
    parameter int DAT_PULSES  = 1024,
    parameter int SYNC_HI     = 601,
    parameter int SYNC_LO     = 791,
    parameter int ZERO_HALF   = 795,
    parameter int ONE_HALF    = 1585,
    parameter int GAP_TICKS   = 3250000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce,
`ifdef ACE_TAPE_PAUSE_EN
    input  logic          pause,
`endif
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] file_size,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    input  logic          rd_ack,
    output logic          ear,
    output logic          busy,
    output logic [7:0]    block_cnt
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_LO = 4'd1,
        S_LEN_HI = 4'd2,
        S_LEADER = 4'd3,
        S_SYNC_H = 4'd4,
        S_SYNC_L = 4'd5,
        S_FETCH  = 4'd6,
        S_BIT_H  = 4'd7,
        S_BIT_L  = 4'd8,
        S_GAP    = 4'd9
    } state_t;

    // Counters are loaded with (duration - 1) and expire on the ce tick at zero.
    localparam logic [21:0] c_leader_ld  = 22'(LEADER_HALF - 1);
    localparam logic [21:0] c_sync_hi_ld = 22'(SYNC_HI - 1);
    localparam logic [21:0] c_sync_lo_ld = 22'(SYNC_LO - 1);
    localparam logic [21:0] c_zero_ld    = 22'(ZERO_HALF - 1);
    localparam logic [21:0] c_one_ld     = 22'(ONE_HALF - 1);
    localparam logic [21:0] c_gap_ld     = 22'(GAP_TICKS - 1);
    localparam logic [15:0] c_hdr_halves = 16'(2 * HDR_PULSES);
    localparam logic [15:0] c_dat_halves = 16'(2 * DAT_PULSES);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_size;
    logic [7:0]    r_len_lo;
    logic [15:0]   r_remain;     // data bytes of the current block not yet fetched
    logic [7:0]    r_byte;
    logic [2:0]    r_bit;
    logic [21:0]   r_cnt;
    logic [15:0]   r_halves;     // leader half-periods left, including the current one
    logic          r_ear;
    logic          r_rd_req;
    logic [7:0]    r_block_cnt;

    logic          w_pause;
    logic          w_tick;
    logic          w_seg_done;
    logic          w_ack;
    logic          w_at_end;
    logic          w_fetching;
    logic          w_abort;
    logic          w_start_ok;
    logic [15:0]   w_len;
    logic [21:0]   w_next_bit_ld;

`ifdef ACE_TAPE_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_tick        = ce & ~w_pause;
    assign w_seg_done    = w_tick & (r_cnt == 22'd0);
    assign w_ack         = r_rd_req & rd_ack;
    assign w_at_end      = (r_ptr >= r_size);
    assign w_fetching    = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_FETCH);
    assign w_abort       = stop & (r_state != S_IDLE);
    assign w_start_ok    = start & (file_size >= AW'(2));
    assign w_len         = {rd_data, r_len_lo};
    // Half-period of the bit that follows the one currently on the line.
    assign w_next_bit_ld = r_byte[r_bit - 3'd1] ? c_one_ld : c_zero_ld;

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_ack)                                       w_state_next = S_LEN_HI;
                else if (!r_rd_req && w_at_end && !w_pause)      w_state_next = S_IDLE;
            end
            S_LEN_HI: begin
                if (w_ack)                                       w_state_next = (w_len == 16'd0) ? S_GAP : S_LEADER;
                else if (!r_rd_req && w_at_end && !w_pause)      w_state_next = S_IDLE;
            end
            S_LEADER: begin
                if (w_seg_done && (r_halves == 16'd1))           w_state_next = S_SYNC_H;
            end
            S_SYNC_H: begin
                if (w_seg_done)                                  w_state_next = S_SYNC_L;
            end
            S_SYNC_L: begin
                if (w_seg_done)                                  w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_ack)                                       w_state_next = S_BIT_H;
                else if (!r_rd_req && w_at_end && !w_pause)      w_state_next = S_IDLE;
            end
            S_BIT_H: begin
                if (w_seg_done)                                  w_state_next = S_BIT_L;
            end
            S_BIT_L: begin
                if (w_seg_done) begin
                    if (r_bit != 3'd0)                           w_state_next = S_BIT_H;
                    else if (r_remain == 16'd0)                  w_state_next = S_GAP;
                    else                                         w_state_next = S_FETCH;
                end
            end
            S_GAP: begin
                if (w_seg_done)                                  w_state_next = w_at_end ? S_IDLE : S_LEN_LO;
            end
            default:                                             w_state_next = S_IDLE;
        endcase
        if (w_abort) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_size      <= '0;
            r_len_lo    <= '0;
            r_remain    <= '0;
            r_byte      <= '0;
            r_bit       <= '0;
            r_cnt       <= '0;
            r_halves    <= '0;
            r_ear       <= 1'b0;
            r_rd_req    <= 1'b0;
            r_block_cnt <= '0;
        end else if (w_abort) begin
            r_rd_req <= 1'b0;
            r_ear    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // rd_ack arriving here belongs to an aborted request and is dropped.
                    if (w_start_ok) begin
                        r_ptr  <= '0;
                        r_size <= file_size;
                        r_ear  <= 1'b0;
                    end
                end
                S_LEN_LO, S_LEN_HI, S_FETCH: begin
                    if (w_ack) begin
                        // Request drops on the acknowledge edge; the next one is
                        // raised no earlier than the following cycle.
                        r_rd_req <= 1'b0;
                        r_ptr    <= r_ptr + AW'(1);
                        if (r_state == S_LEN_LO) begin
                            r_len_lo <= rd_data;
                        end else if (r_state == S_LEN_HI) begin
                            r_remain <= w_len;
                            if (w_len == 16'd0) begin
                                r_cnt       <= c_gap_ld;
                                r_block_cnt <= r_block_cnt + 8'd1;
                            end else begin
                                r_cnt    <= c_leader_ld;
                                r_halves <= r_block_cnt[0] ? c_dat_halves : c_hdr_halves;
                                r_ear    <= 1'b1;
                            end
                        end else begin
                            r_byte   <= rd_data;
                            r_remain <= r_remain - 16'd1;
                            r_bit    <= 3'd7;
                            r_cnt    <= rd_data[7] ? c_one_ld : c_zero_ld;
                            r_ear    <= 1'b1;
                        end
                    end else if (!r_rd_req && !w_at_end && !w_pause) begin
                        r_rd_req <= 1'b1;
                    end
                end
                S_LEADER: begin
                    if (w_seg_done) begin
                        if (r_halves == 16'd1) begin
                            r_cnt <= c_sync_hi_ld;
                            r_ear <= 1'b1;
                        end else begin
                            r_halves <= r_halves - 16'd1;
                            r_cnt    <= c_leader_ld;
                            r_ear    <= ~r_ear;
                        end
                    end else if (w_tick) begin
                        r_cnt <= r_cnt - 22'd1;
                    end
                end
                S_SYNC_H: begin
                    if (w_seg_done) begin
                        r_cnt <= c_sync_lo_ld;
                        r_ear <= 1'b0;
                    end else if (w_tick) begin
                        r_cnt <= r_cnt - 22'd1;
                    end
                end
                S_SYNC_L: begin
                    if (w_tick && !w_seg_done) r_cnt <= r_cnt - 22'd1;
                end
                S_BIT_H: begin
                    if (w_seg_done) begin
                        r_cnt <= r_byte[r_bit] ? c_one_ld : c_zero_ld;
                        r_ear <= 1'b0;
                    end else if (w_tick) begin
                        r_cnt <= r_cnt - 22'd1;
                    end
                end
                S_BIT_L: begin
                    if (w_seg_done) begin
                        if (r_bit != 3'd0) begin
                            r_bit <= r_bit - 3'd1;
                            r_cnt <= w_next_bit_ld;
                            r_ear <= 1'b1;
                        end else if (r_remain == 16'd0) begin
                            r_cnt       <= c_gap_ld;
                            r_block_cnt <= r_block_cnt + 8'd1;
                        end
                    end else if (w_tick) begin
                        r_cnt <= r_cnt - 22'd1;
                    end
                end
                S_GAP: begin
                    if (w_tick && !w_seg_done) r_cnt <= r_cnt - 22'd1;
                end
                default: begin
                    r_rd_req <= 1'b0;
                    r_ear    <= 1'b0;
                end
            endcase
        end
    end

    assign rd_req    = r_rd_req;
    assign rd_addr   = r_ptr;
    assign ear       = r_ear;
    assign busy      = (r_state != S_IDLE);
    assign block_cnt = r_block_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ace_tape_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ace_tape_player
//  Description : Scoreboard bench for ace_tape_player. A reference model turns
//                each tape image into the expected list of read addresses and
//                ear pulse widths (in ce ticks). Independent monitors compare
//                acknowledged reads and measured ear segments against them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ace_tape_player;

    localparam int AW  = 8;
    localparam int LH  = 4;
    localparam int HDR = 3;
    localparam int DAT = 2;
    localparam int SH  = 2;
    localparam int SL  = 3;
    localparam int ZH  = 2;
    localparam int OH  = 4;
    localparam int GAP = 5;
    localparam int BUDGET = 20000;

    typedef struct {
        bit lvl;
        int ticks;   // -1: duration depends on fetch latency, not checked
    } seg_t;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b0;
    logic          ce      = 1'b0;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic [AW-1:0] file_size = '0;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = '0;
    logic          rd_ack  = 1'b0;
    logic          ear;
    logic          busy;
    logic [7:0]    block_cnt;
`ifdef ACE_TAPE_PAUSE_EN
    logic          pause = 1'b0;
`endif

    logic [7:0] mem [0:255];
    int   exp_addr[$];
    seg_t exp_seg[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   blk   = 0;
    bit   mon_en = 0;
    bit   addr_chk_en = 0;
    bit   late_ack = 0;

    ace_tape_player #(
        .AW(AW), .LEADER_HALF(LH), .HDR_PULSES(HDR), .DAT_PULSES(DAT),
        .SYNC_HI(SH), .SYNC_LO(SL), .ZERO_HALF(ZH), .ONE_HALF(OH), .GAP_TICKS(GAP)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce       (ce),
`ifdef ACE_TAPE_PAUSE_EN
        .pause    (pause),
`endif
        .start    (start),
        .stop     (stop),
        .file_size(file_size),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ack   (rd_ack),
        .ear      (ear),
        .busy     (busy),
        .block_cnt(block_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    // ce high on every second clock edge
    initial forever begin
        @(posedge clk_sys); #1;
        ce = ~ce;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Memory model: acknowledges 3 cycles after a request, checks the address.
    initial begin
        int age = 0;
        forever begin
            @(posedge clk_sys); #1;
            rd_ack = 1'b0;
            if (late_ack) begin
                rd_ack   = 1'b1;
                rd_data  = 8'h5A;
                late_ack = 0;
            end else if (rd_req) begin
                age++;
                if (age == 3) begin
                    rd_ack  = 1'b1;
                    rd_data = mem[rd_addr];
                    age     = 0;
                    if (addr_chk_en) begin
                        if (exp_addr.size() == 0) chk("rd_addr_unexpected", longint'(rd_addr), -1);
                        else chk("rd_addr", longint'(rd_addr), longint'(exp_addr.pop_front()));
                    end
                end
            end else begin
                age = 0;
            end
        end
    end

    // Ear monitor: measures each constant-level segment in ce ticks.
    initial begin
        bit cur = 0;
        int ticks = 0;
        seg_t s;
        forever begin
            @(negedge clk_sys);
            if (!mon_en) begin
                cur = ear; ticks = 0;
            end else begin
                if (ear !== cur) begin
                    if (exp_seg.size() == 0) begin
                        if (cur) chk("ear_unexpected_high", ticks, -1);
                    end else if (exp_seg[0].lvl == cur) begin
                        s = exp_seg.pop_front();
                        if (s.ticks >= 0) chk(cur ? "ear_high_width" : "ear_low_width", ticks, s.ticks);
                    end else if (cur) begin
                        s = exp_seg.pop_front();
                        chk("ear_level", 1, 0);
                    end
                    cur = ear; ticks = 0;
                end
                if (ce) ticks++;
            end
        end
    end

    task automatic push_seg(input bit l, input int t);
        seg_t s;
        s.lvl = l; s.ticks = t;
        exp_seg.push_back(s);
    endtask

    // Reference model: walk the image the way the tape format defines it.
    task automatic model_run(input int size);
        int ptr = 0;
        int len;
        int n;
        bit clamp = 0;
        logic [7:0] b;
        if (size < 2) return;
        while (ptr < size) begin
            exp_addr.push_back(ptr); len = int'(mem[ptr]); ptr++;
            if (ptr >= size) break;
            exp_addr.push_back(ptr); len += 256 * int'(mem[ptr]); ptr++;
            if (len != 0) begin
                n = (blk % 2 == 0) ? HDR : DAT;
                for (int i = 0; i < n; i++) begin
                    push_seg(1, LH); push_seg(0, LH);
                end
                push_seg(1, SH); push_seg(0, -1);
                for (int k = 0; k < len; k++) begin
                    if (ptr >= size) begin clamp = 1; break; end
                    exp_addr.push_back(ptr); b = mem[ptr]; ptr++;
                    for (int j = 7; j >= 0; j--) begin
                        push_seg(1, b[j] ? OH : ZH);
                        push_seg(0, (j == 0) ? -1 : (b[j] ? OH : ZH));
                    end
                end
            end
            if (clamp) break;
            blk = (blk + 1) % 256;
        end
        if (exp_seg.size() > 0 && exp_seg[exp_seg.size()-1].lvl == 0) void'(exp_seg.pop_back());
    endtask

    task automatic pulse_start(input int size);
        file_size = AW'(size);
        start = 1'b1;
        @(posedge clk_sys); #2;
        start = 1'b0;
        file_size = '0;
    endtask

    task automatic run_image(input int size);
        int cyc = 0;
        model_run(size);
        addr_chk_en = 1; mon_en = 1;
        pulse_start(size);
        while (busy && cyc < BUDGET) begin
            @(posedge clk_sys); #2; cyc++;
        end
        if (cyc >= BUDGET) chk("run_timeout", cyc, 0);
        @(negedge clk_sys); @(negedge clk_sys);
        chk("block_cnt", block_cnt, blk);
        chk("end_rd_req", rd_req, 0);
        chk("end_ear", ear, 0);
        chk("addr_left", exp_addr.size(), 0);
        chk("seg_left", exp_seg.size(), 0);
        exp_addr.delete(); exp_seg.delete();
    endtask

    task automatic load6(input logic [7:0] b0, b1, b2, b3, b4, b5);
        mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3; mem[4] = b4; mem[5] = b5;
    endtask

    task automatic wait_for(input string name, input int what);
        int cyc = 0;
        while (cyc < BUDGET && !((what == 0) ? (rd_req && rd_addr == 8'd3) : (ear == 1'b1))) begin
            @(posedge clk_sys); #2; cyc++;
        end
        if (cyc >= BUDGET) chk(name, cyc, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk_sys);
        #2;
        chk("rst_ear", ear, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_block_cnt", block_cnt, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #2;

        // single block with header leader
        load6(8'h02, 8'h00, 8'hA5, 8'h3C, 8'h00, 8'h00);
        run_image(4);
        // two one-byte blocks
        load6(8'h01, 8'h00, 8'hAA, 8'h01, 8'h00, 8'h55);
        run_image(6);
        // empty block followed by a one-byte block
        load6(8'h00, 8'h00, 8'h01, 8'h00, 8'hC3, 8'h00);
        run_image(5);
        // length beyond end of image is clamped
        load6(8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00);
        run_image(5);
        // images shorter than 2 bytes are ignored
        run_image(1);
        chk("short_busy", busy, 0);

        // stop with a read outstanding, then a late acknowledge
        load6(8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00);
        mon_en = 0; addr_chk_en = 0;
        pulse_start(5);
        wait_for("stop_wait_timeout", 0);
        stop = 1'b1;
        @(posedge clk_sys); #2;
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_rd_req", rd_req, 0);
        chk("stop_ear", ear, 0);
        late_ack = 1;
        repeat (3) @(posedge clk_sys);
        #2;
        chk("late_ack_busy", busy, 0);
        chk("late_ack_rd_req", rd_req, 0);
        run_image(5);

        // reset during the leader
        mon_en = 0; addr_chk_en = 0;
        load6(8'h02, 8'h00, 8'hA5, 8'h3C, 8'h00, 8'h00);
        pulse_start(4);
        wait_for("leader_wait_timeout", 1);
        reset = 1'b0;
        @(posedge clk_sys); #2;
        chk("mid_rst_ear", ear, 0);
        chk("mid_rst_rd_req", rd_req, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_block_cnt", block_cnt, 0);
        reset = 1'b1;
        blk = 0;
        @(posedge clk_sys); #2;
        run_image(4);

        // random images
        for (int r = 0; r < 8; r++) begin
            int p = 0;
            int nb = $urandom_range(1, 3);
            int sz;
            for (int b = 0; b < nb; b++) begin
                int len = $urandom_range(0, 3);
                mem[p] = 8'(len); mem[p+1] = 8'h00; p += 2;
                for (int k = 0; k < len; k++) begin
                    mem[p] = 8'($urandom); p++;
                end
            end
            sz = p - $urandom_range(0, 2);
            if (sz < 0) sz = 0;
            run_image(sz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
